// File: rtl/alu_mul_seq_if.sv
// ----------------------------------------------------------------------------
// alu_mul_seq_if
// Signal bundle for the sequential multiplier. It carries two things:
//   - the request side: start, op_a, op_b in; busy, done, product out
//   - the shared-ALU side: alu_op, alu_a, alu_b out; alu_result, alu_zero in
// Modports:
//   slave  - the multiplier itself (drives busy/done/product and the ALU inputs)
//   master - the requester, which also closes the loop through the shared ALU
// ----------------------------------------------------------------------------
interface alu_mul_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] product;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    modport slave (
        input  start,
        input  op_a,
        input  op_b,
        output busy,
        output done,
        output product,
        output alu_op,
        output alu_a,
        output alu_b,
        input  alu_result,
        input  alu_zero
    );

    modport master (
        output start,
        output op_a,
        output op_b,
        input  busy,
        input  done,
        input  product,
        input  alu_op,
        input  alu_a,
        input  alu_b,
        output alu_result,
        output alu_zero
    );
endinterface

// File: rtl/alu_mul_seq.sv
// ----------------------------------------------------------------------------
// alu_mul_seq
// Multi-cycle shift-add multiplier that borrows the shared rv32i ALU for its
// additions. It returns the low XLEN bits of op_a * op_b, which are the same
// for signed and unsigned operands, so one datapath serves MUL.
//
// Ports:
//   i_clk  - system clock, all state updates on the rising edge
//   i_rst  - synchronous active-high reset
//   bus    - alu_mul_seq_if.slave:
//              start/op_a/op_b   request and operands (sampled in IDLE or DONE)
//              busy              high while iterating
//              done              one-cycle pulse when product becomes valid
//              product           result, held until the next completed operation
//              alu_op/alu_a/alu_b  drive the shared ALU (ADD while busy, else 0)
//              alu_result        sum returned by the ALU
//              alu_zero          ALU zero flag, not used here
//
// Timing: start accepted at edge E0 -> RUN for XLEN cycles -> done in the
// cycle after edge E0+XLEN. Latency is fixed; there is no early exit.
// ----------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_mul_seq_if.slave  bus
);

    localparam logic [3:0]       AluAdd  = 4'b0010;
    localparam logic [3:0]       AluIdle = 4'b0000;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN-1:0]   r_product;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_last;
    logic [XLEN-1:0]   w_acc_next;

    // The zero flag has no role in a multiply; named so lint treats it as
    // intentionally unused.
    logic              w_unused_alu_zero;
    assign w_unused_alu_zero = bus.alu_zero;

    assign w_last = (r_cnt == LastCnt);

    // Conditional add: the ALU always computes acc + mcand while running, we
    // only keep the sum when the current multiplier bit is set.
    assign w_acc_next = r_mplier[0] ? bus.alu_result : r_acc;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                // start is deliberately ignored here
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (bus.start) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // ALU drive: only touch the shared ALU while iterating, park at zero
    // otherwise so other users see a quiet input.
    // ------------------------------------------------------------------------
    always_comb begin
        bus.alu_op = AluIdle;
        bus.alu_a  = '0;
        bus.alu_b  = '0;
        if (r_state == StRun) begin
            bus.alu_op = AluAdd;
            bus.alu_a  = r_acc;
            bus.alu_b  = r_mcand;
        end
    end

    assign bus.busy    = (r_state == StRun);
    assign bus.done    = (r_state == StDone);
    assign bus.product = r_product;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_acc    <= '0;
                r_mcand  <= bus.op_a;
                r_mplier <= bus.op_b;
                r_cnt    <= '0;
            end else if (r_state == StRun) begin
                r_acc    <= w_acc_next;
                r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                r_cnt    <= r_cnt + CNT_W'(1);
                // Final iteration: publish the sum including this edge's add.
                if (w_last) begin
                    r_product <= w_acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    localparam int unsigned XLEN = 32;

    logic clk;
    logic rst;

    int total;
    int bad;

    logic [XLEN-1:0] sb[$];

    alu_mul_seq_if #(.XLEN(XLEN)) bus_if ();

    alu_mul_seq #(.XLEN(XLEN)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_if)
    );

    // Reference model of the shared combinational ALU (ADD and AND only).
    assign bus_if.alu_result = (bus_if.alu_op == 4'b0010) ? (bus_if.alu_a + bus_if.alu_b)
                                                          : (bus_if.alu_a & bus_if.alu_b);
    assign bus_if.alu_zero   = (bus_if.alu_result == '0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one operation and follows it until done (or a bound expires).
    // Samples #1 after each rising edge. lat counts edges from the accepting
    // edge inclusive, so a correct run ends with lat == XLEN + 1.
    task automatic run_op(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input bit keep, input int pulse_at, input int rst_at,
                          output int lat, output int busy_cnt, output int alu_bad,
                          output bit got_done);
        bus_if.op_a  = a;
        bus_if.op_b  = b;
        bus_if.start = 1'b1;
        lat      = 0;
        busy_cnt = 0;
        alu_bad  = 0;
        got_done = 1'b0;
        while (!got_done && lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1 && !keep) bus_if.start = 1'b0;
            if (lat == 2) begin
                bus_if.op_a = $urandom;
                bus_if.op_b = $urandom;
            end
            if (bus_if.busy) busy_cnt++;
            if (bus_if.busy) begin
                if (bus_if.alu_op !== 4'b0010) alu_bad++;
            end else begin
                if (bus_if.alu_op !== 4'b0000 || bus_if.alu_a !== '0 || bus_if.alu_b !== '0)
                    alu_bad++;
            end
            if (pulse_at != 0 && lat == pulse_at) begin
                bus_if.start = 1'b1;
                bus_if.op_a  = 32'd9;
                bus_if.op_b  = 32'd9;
            end
            if (pulse_at != 0 && lat == pulse_at + 1) begin
                bus_if.start = 1'b0;
                bus_if.op_a  = $urandom;
                bus_if.op_b  = $urandom;
            end
            if (bus_if.done) got_done = 1'b1;
            if (rst_at != 0 && lat == rst_at) begin
                rst = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        total++;
        if (bus_if.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: got %b want 0", bus_if.busy);
        end
        total++;
        if (bus_if.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done: got %b want 0", bus_if.done);
        end
        total++;
        if (bus_if.product !== '0) begin
            bad++;
            $display("FAIL reset_product: got %h want 0", bus_if.product);
        end
        total++;
        if (bus_if.alu_op !== 4'b0000 || bus_if.alu_a !== '0 || bus_if.alu_b !== '0) begin
            bad++;
            $display("FAIL reset_alu: got op=%b a=%h b=%h want 0", bus_if.alu_op,
                     bus_if.alu_a, bus_if.alu_b);
        end
    endtask

    // Runs one op with scoreboard bookkeeping and latency/ALU-drive checks.
    task automatic do_op(input string name, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b);
        int lat, bc, ab;
        bit gd;
        logic [XLEN-1:0] exp;
        sb.push_back(a * b);
        run_op(a, b, 1'b0, 0, 0, lat, bc, ab, gd);
        total++;
        if (!gd || lat != XLEN + 1) begin
            bad++;
            $display("FAIL %s_latency: got %0d (done=%b) want %0d", name, lat, gd, XLEN + 1);
        end
        total++;
        if (bc != XLEN) begin
            bad++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, bc, XLEN);
        end
        total++;
        if (ab != 0) begin
            bad++;
            $display("FAIL %s_alu_drive: got %0d bad cycles want 0", name, ab);
        end
        exp = sb.pop_front();
        total++;
        if (bus_if.product !== exp) begin
            bad++;
            $display("FAIL %s_product: got %h want %h", name, bus_if.product, exp);
        end
    endtask

    task automatic test_basic();
        logic [XLEN-1:0] exp;
        do_op("mul_3x5", 32'd3, 32'd5);
        exp = 32'd15;
        // done is a single-cycle pulse and product holds afterwards
        @(posedge clk);
        #1;
        total++;
        if (bus_if.done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_width: got %b want 0", bus_if.done);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus_if.product !== exp) begin
            bad++;
            $display("FAIL product_hold_idle: got %h want %h", bus_if.product, exp);
        end
    endtask

    task automatic test_wrap();
        do_op("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mul_msb_x2", 32'h8000_0000, 32'd2);
    endtask

    task automatic test_no_early_exit();
        do_op("mul_by_zero", 32'h1234_5678, 32'd0);
        do_op("mul_by_one", 32'hDEAD_BEEF, 32'd1);
        do_op("mul_rand", 32'h0001_3579, 32'h0000_2468);
    endtask

    task automatic test_ignore_start();
        int lat, bc, ab;
        bit gd;
        logic [XLEN-1:0] exp;
        sb.push_back(32'd42);
        run_op(32'd7, 32'd6, 1'b0, 10, 0, lat, bc, ab, gd);
        total++;
        if (!gd || lat != XLEN + 1) begin
            bad++;
            $display("FAIL ignore_latency: got %0d (done=%b) want %0d", lat, gd, XLEN + 1);
        end
        exp = sb.pop_front();
        total++;
        if (bus_if.product !== exp) begin
            bad++;
            $display("FAIL ignore_product: got %h want %h", bus_if.product, exp);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
            bad++;
            $display("FAIL ignore_no_restart: got busy=%b done=%b want 0 0",
                     bus_if.busy, bus_if.done);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, ab;
        bit gd;
        logic [XLEN-1:0] exp;
        sb.push_back(32'd42);
        run_op(32'd7, 32'd6, 1'b1, 0, 0, lat, bc, ab, gd);
        exp = sb.pop_front();
        total++;
        if (!gd || lat != XLEN + 1 || bus_if.product !== exp) begin
            bad++;
            $display("FAIL b2b_first: got lat=%0d done=%b product=%h want lat=%0d product=%h",
                     lat, gd, bus_if.product, XLEN + 1, exp);
        end
        // Still in the DONE cycle with start high: present the next operands.
        sb.push_back(32'd100);
        run_op(32'd10, 32'd10, 1'b1, 0, 0, lat, bc, ab, gd);
        bus_if.start = 1'b0;
        exp = sb.pop_front();
        total++;
        if (!gd || lat != XLEN + 1) begin
            bad++;
            $display("FAIL b2b_gap: got %0d (done=%b) want %0d", lat, gd, XLEN + 1);
        end
        total++;
        if (bc != XLEN) begin
            bad++;
            $display("FAIL b2b_busy_cycles: got %0d want %0d", bc, XLEN);
        end
        total++;
        if (bus_if.product !== exp) begin
            bad++;
            $display("FAIL b2b_second: got %h want %h", bus_if.product, exp);
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, ab;
        bit gd;
        int seen_done;
        sb.push_back(32'h0000_FFFF * 32'h0000_FFFF);
        run_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 0, 15, lat, bc, ab, gd);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.product !== '0) begin
            bad++;
            $display("FAIL midrun_reset: got busy=%b done=%b product=%h want 0 0 0",
                     bus_if.busy, bus_if.done, bus_if.product);
        end
        seen_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) seen_done++;
        end
        total++;
        if (seen_done != 0) begin
            bad++;
            $display("FAIL midrun_idle: got %0d active cycles want 0", seen_done);
        end
        do_op("after_reset_2x3", 32'd2, 32'd3);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_if.start = 1'b0;
        bus_if.op_a  = '0;
        bus_if.op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_no_early_exit();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
